// File: rtl/vram_prefetch.sv
// Scan-out read front end: holds the current VRAM word and prefetches the next sequential one.
// Optional demand-miss counter on the miss_cnt port when VRAM_PREFETCH_STATS_EN is defined.
module vram_prefetch #(
    parameter int ADDR_W  = 14,
    parameter int TIMEOUT = 15
) (
    input  logic              clk_sys,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] vram_addr,
    output logic [15:0]       vram_data,
    output logic              vram_valid,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    input  logic              mem_ack,
    input  logic [15:0]       mem_data
`ifdef VRAM_PREFETCH_STATS_EN
    ,
    output logic [15:0]       miss_cnt
`endif
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;

    typedef struct packed {
        logic              vld;
        logic [ADDR_W-1:0] tag;
        logic [15:0]       data;
    } entry_t;

    localparam logic [ADDR_W-1:0] ONE      = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [3:0]        TMO_LAST = 4'(TIMEOUT - 1);

    state_t            state_q, state_d;
    entry_t            ent_c_q, ent_c_d, ent_n_q, ent_n_d;
    logic [ADDR_W-1:0] cur_addr_q;
    logic              force_q, force_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic              mem_rd_q, mem_rd_d;
    logic              req_dem_q, req_dem_d;
    logic              pend_dem_q, pend_dem_d;
    logic [ADDR_W-1:0] dem_addr_q, dem_addr_d;
    logic              pend_pf_q, pend_pf_d;
    logic [ADDR_W-1:0] pf_addr_q, pf_addr_d;
    logic [3:0]        tmo_q, tmo_d;
    logic              miss_ev;

    logic              change, ack_ok, dem_fill, pf_fill;
    logic [ADDR_W-1:0] addr_inc;

    assign change   = (vram_addr != cur_addr_q) || force_q;
    assign addr_inc = vram_addr + ONE;
    assign ack_ok   = (state_q == S_WAIT) && mem_ack;
    // Fills are judged against the address wanted right now, so a same-cycle change wins.
    assign dem_fill = ack_ok && req_dem_q && (mem_addr_q == vram_addr);
    assign pf_fill  = ack_ok && !req_dem_q &&
                      ((mem_addr_q == addr_inc) || (mem_addr_q == vram_addr));

    always_comb begin
        state_d    = state_q;
        ent_c_d    = ent_c_q;
        ent_n_d    = ent_n_q;
        force_d    = force_q;
        mem_addr_d = mem_addr_q;
        mem_rd_d   = mem_rd_q;
        req_dem_d  = req_dem_q;
        pend_dem_d = pend_dem_q;
        dem_addr_d = dem_addr_q;
        pend_pf_d  = pend_pf_q;
        pf_addr_d  = pf_addr_q;
        tmo_d      = tmo_q;
        miss_ev    = 1'b0;

        case (state_q)
            S_IDLE: begin
                // Hold off dispatch for a cycle while a change re-targets the pending work.
                if (!change) begin
                    if (pend_dem_q) begin
                        state_d    = S_REQ;
                        mem_addr_d = dem_addr_q;
                        mem_rd_d   = 1'b1;
                        req_dem_d  = 1'b1;
                        pend_dem_d = 1'b0;
                    end else if (pend_pf_q) begin
                        state_d    = S_REQ;
                        mem_addr_d = pf_addr_q;
                        mem_rd_d   = 1'b1;
                        req_dem_d  = 1'b0;
                        pend_pf_d  = 1'b0;
                    end
                end
            end
            S_REQ: begin
                state_d = S_WAIT;
                tmo_d   = 4'd0;
            end
            S_WAIT: begin
                if (mem_ack) begin
                    mem_rd_d = 1'b0;
                    state_d  = S_IDLE;
                end else if (tmo_q == TMO_LAST) begin
                    mem_rd_d = 1'b0;
                    state_d  = S_IDLE;
                    if (req_dem_q && (mem_addr_q == vram_addr)) begin
                        pend_dem_d = 1'b1;
                        dem_addr_d = mem_addr_q;
                    end
                end else begin
                    tmo_d = tmo_q + 4'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (dem_fill) begin
            ent_c_d    = '{vld: 1'b1, tag: mem_addr_q, data: mem_data};
            pend_dem_d = 1'b0;
            pend_pf_d  = 1'b1;
            pf_addr_d  = mem_addr_q + ONE;
        end
        if (pf_fill)
            ent_n_d = '{vld: 1'b1, tag: mem_addr_q, data: mem_data};

        // Change is resolved against the post-fill entries.
        if (change) begin
            force_d = 1'b0;
            if (dem_fill) begin
                pend_dem_d = 1'b0;
            end else if (ent_n_d.vld && (ent_n_d.tag == vram_addr)) begin
                ent_c_d     = ent_n_d;
                ent_n_d.vld = 1'b0;
                pend_dem_d  = 1'b0;
                pend_pf_d   = 1'b1;
                pf_addr_d   = addr_inc;
            end else begin
                ent_c_d.vld = 1'b0;
                pend_dem_d  = 1'b1;
                dem_addr_d  = vram_addr;
                pend_pf_d   = 1'b0;
                miss_ev     = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            ent_c_q    <= '0;
            ent_n_q    <= '0;
            cur_addr_q <= '0;
            force_q    <= 1'b1;
            mem_addr_q <= '0;
            mem_rd_q   <= 1'b0;
            req_dem_q  <= 1'b0;
            pend_dem_q <= 1'b0;
            dem_addr_q <= '0;
            pend_pf_q  <= 1'b0;
            pf_addr_q  <= '0;
            tmo_q      <= 4'd0;
        end else begin
            state_q    <= state_d;
            ent_c_q    <= ent_c_d;
            ent_n_q    <= ent_n_d;
            cur_addr_q <= vram_addr;
            force_q    <= force_d;
            mem_addr_q <= mem_addr_d;
            mem_rd_q   <= mem_rd_d;
            req_dem_q  <= req_dem_d;
            pend_dem_q <= pend_dem_d;
            dem_addr_q <= dem_addr_d;
            pend_pf_q  <= pend_pf_d;
            pf_addr_q  <= pf_addr_d;
            tmo_q      <= tmo_d;
        end
    end

`ifdef VRAM_PREFETCH_STATS_EN
    logic [15:0] miss_q;
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n)
            miss_q <= 16'd0;
        else if (miss_ev && (miss_q != 16'hFFFF))
            miss_q <= miss_q + 16'd1;
    end
    assign miss_cnt = miss_q;
`else
    logic unused_miss;
    assign unused_miss = miss_ev;
`endif

    assign vram_data  = ent_c_q.data;
    assign vram_valid = ent_c_q.vld && (ent_c_q.tag == cur_addr_q);
    assign mem_addr   = mem_addr_q;
    assign mem_rd     = mem_rd_q;

endmodule

// File: tb/tb_vram_prefetch.sv
// Scoreboard bench for vram_prefetch: stimulus queues expected requests/words, a monitor pops them.
module tb_vram_prefetch;
    localparam int AW = 14;

    logic          clk_sys = 1'b0;
    logic          reset_n = 1'b0;
    logic [AW-1:0] vram_addr = '0;
    logic [15:0]   vram_data;
    logic          vram_valid;
    logic [AW-1:0] mem_addr;
    logic          mem_rd;
    logic          mem_ack = 1'b0;
    logic [15:0]   mem_data = '0;
`ifdef VRAM_PREFETCH_STATS_EN
    logic [15:0]   miss_cnt;
`endif

    vram_prefetch #(.ADDR_W(AW), .TIMEOUT(15)) dut (
        .clk_sys(clk_sys), .reset_n(reset_n), .vram_addr(vram_addr),
        .vram_data(vram_data), .vram_valid(vram_valid),
        .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_ack(mem_ack), .mem_data(mem_data)
`ifdef VRAM_PREFETCH_STATS_EN
        , .miss_cnt(miss_cnt)
`endif
    );

    always #5 clk_sys = ~clk_sys;

    int n_checks = 0;
    int n_fail   = 0;
    logic [AW-1:0] exp_req[$];
    logic [AW-1:0] exp_val[$];
    int ack_lat  = 2;
    bit drop_req = 1'b0;

    function automatic logic [15:0] ram_word(input logic [AW-1:0] a);
        return {a[5:0], a[13:4]} ^ 16'hC35A;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic wait_valid(output int cyc);
        cyc = 0;
        do begin
            tick();
            cyc++;
        end while (!vram_valid && cyc < 80);
        if (!vram_valid) begin
            n_checks++; n_fail++;
            $display("FAIL wait_valid: timed out after %0d cycles", cyc);
        end
    endtask

    task automatic wait_rd(input logic level);
        int c = 0;
        while (mem_rd !== level && c < 80) begin
            tick();
            c++;
        end
        if (mem_rd !== level) begin
            n_checks++; n_fail++;
            $display("FAIL wait_rd: mem_rd never reached %0b", level);
        end
    endtask

    task automatic settle();
        int low = 0;
        int c   = 0;
        while (low < 4 && c < 120) begin
            tick();
            c++;
            low = mem_rd ? 0 : low + 1;
        end
        if (low < 4) begin
            n_checks++; n_fail++;
            $display("FAIL settle: bus never went idle");
        end
    endtask

    // RAM responder: acks ack_lat cycles after mem_rd rises; drop_req withholds the ack
    // and fires a stray ack in the first idle cycle after the request is abandoned.
    initial begin
        int  rd_cnt  = 0;
        bit  prev_rd = 1'b0;
        forever begin
            @(posedge clk_sys);
            #1;
            mem_ack = 1'b0;
            if (mem_rd) begin
                rd_cnt++;
                if (!drop_req && rd_cnt == ack_lat) begin
                    mem_ack  = 1'b1;
                    mem_data = ram_word(mem_addr);
                end
                prev_rd = 1'b1;
            end else begin
                if (prev_rd && drop_req) begin
                    mem_ack  = 1'b1;
                    mem_data = 16'hDEAD;
                    drop_req = 1'b0;
                end
                rd_cnt  = 0;
                prev_rd = 1'b0;
            end
        end
    end

    // Monitor: every new request and every rise of vram_valid is matched to the scoreboard.
    initial begin
        logic prev_rd  = 1'b0;
        logic prev_val = 1'b0;
        logic [AW-1:0] a;
        forever begin
            @(negedge clk_sys);
            if (mem_rd && !prev_rd) begin
                if (exp_req.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL unexpected_req: mem_addr=%0h with nothing expected", mem_addr);
                end else begin
                    a = exp_req.pop_front();
                    check("req_addr", 32'(mem_addr), 32'(a));
                end
            end
            if (vram_valid && !prev_val) begin
                if (exp_val.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL unexpected_valid: vram_data=%0h with nothing expected", vram_data);
                end else begin
                    a = exp_val.pop_front();
                    check("vram_data", 32'(vram_data), 32'(ram_word(a)));
                end
            end
            prev_rd  = mem_rd;
            prev_val = vram_valid;
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail + 1);
        $fatal(1);
    end

    initial begin
        int cyc, hi, gap;

        // Reset and cold start on 0100
        vram_addr = 14'h0100;
        ack_lat   = 2;
        repeat (3) tick();
        check("rst_valid", 32'(vram_valid), 32'd0);
        check("rst_data", 32'(vram_data), 32'd0);
        check("rst_rd", 32'(mem_rd), 32'd0);
        check("rst_addr", 32'(mem_addr), 32'd0);
        exp_req.push_back(14'h0100);
        exp_req.push_back(14'h0101);
        exp_val.push_back(14'h0100);
        reset_n = 1'b1;
        wait_valid(cyc);
        check("cold_latency", 32'(cyc), 32'd4);
        settle();
`ifdef VRAM_PREFETCH_STATS_EN
        check("miss_cnt_1", 32'(miss_cnt), 32'd1);
`endif

        // Sequential step hits the prefetched word
        exp_req.push_back(14'h0102);
        vram_addr = 14'h0101;
        tick();
        check("hit_valid", 32'(vram_valid), 32'd1);
        check("hit_data", 32'(vram_data), 32'(ram_word(14'h0101)));
        settle();
`ifdef VRAM_PREFETCH_STATS_EN
        check("miss_cnt_hit", 32'(miss_cnt), 32'd1);
`endif

        // Top of address space: prefetch wraps to 0000, then 0000 is a hit
        exp_req.push_back(14'h3FFF);
        exp_req.push_back(14'h0000);
        exp_val.push_back(14'h3FFF);
        vram_addr = 14'h3FFF;
        wait_valid(cyc);
        settle();
        exp_req.push_back(14'h0001);
        vram_addr = 14'h0000;
        tick();
        check("wrap_valid", 32'(vram_valid), 32'd1);
        check("wrap_data", 32'(vram_data), 32'(ram_word(14'h0000)));
        settle();

        // Jump away while the 0103 prefetch is in flight
        ack_lat = 6;
        exp_req.push_back(14'h0102);
        exp_req.push_back(14'h0103);
        exp_val.push_back(14'h0102);
        vram_addr = 14'h0102;
        wait_valid(cyc);
        wait_rd(1'b1);
        tick();
        tick();
        exp_req.push_back(14'h2000);
        exp_req.push_back(14'h2001);
        exp_val.push_back(14'h2000);
        vram_addr = 14'h2000;
        tick();
        check("jump_invalid", 32'(vram_valid), 32'd0);
        wait_rd(1'b0);
        check("jump_invalid_at_ack", 32'(vram_valid), 32'd0);
        gap = 0;
        while (!mem_rd && gap < 40) begin gap++; tick(); end
        check("jump_demand_gap", 32'(gap), 32'd1);
        settle();
`ifdef VRAM_PREFETCH_STATS_EN
        check("miss_cnt_jump", 32'(miss_cnt), 32'd4);
`endif

        // Withheld ack: timeout, re-issue, stray ack in IDLE ignored
        ack_lat  = 2;
        drop_req = 1'b1;
        exp_req.push_back(14'h1234);
        exp_req.push_back(14'h1234);
        exp_req.push_back(14'h1235);
        exp_val.push_back(14'h1234);
        vram_addr = 14'h1234;
        wait_rd(1'b1);
        hi = 0;
        while (mem_rd && hi < 40) begin hi++; tick(); end
        check("timeout_rd_cycles", 32'(hi), 32'd16);
        gap = 0;
        while (!mem_rd && gap < 40) begin gap++; tick(); end
        check("timeout_reissue_gap", 32'(gap), 32'd1);
        wait_valid(cyc);
        check("timeout_fill_data", 32'(vram_data), 32'(ram_word(14'h1234)));
        settle();
`ifdef VRAM_PREFETCH_STATS_EN
        check("miss_cnt_timeout", 32'(miss_cnt), 32'd5);
`endif

        // Reset in the middle of a request
        ack_lat = 10;
        exp_req.push_back(14'h0777);
        vram_addr = 14'h0777;
        wait_rd(1'b1);
        repeat (3) tick();
        #2;
        reset_n = 1'b0;
        #1;
        check("async_rd", 32'(mem_rd), 32'd0);
        check("async_valid", 32'(vram_valid), 32'd0);
        check("async_data", 32'(vram_data), 32'd0);
        check("async_addr", 32'(mem_addr), 32'd0);
        ack_lat = 2;
        exp_req.push_back(14'h0777);
        exp_req.push_back(14'h0778);
        exp_val.push_back(14'h0777);
        tick();
        tick();
        reset_n = 1'b1;
        wait_valid(cyc);
        check("restart_latency", 32'(cyc), 32'd4);
        settle();
`ifdef VRAM_PREFETCH_STATS_EN
        check("miss_cnt_restart", 32'(miss_cnt), 32'd1);
`endif

        check("req_queue_drained", 32'(exp_req.size()), 32'd0);
        check("val_queue_drained", 32'(exp_val.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/vram_prefetch.md
Name: vram_prefetch

Overview:
Read-side front end for the video scan-out stage. It takes the word address the video block drives each 16-pixel group, returns the 16-bit pixel word from shared RAM over a request/acknowledge memory port, and prefetches the next sequential word. The video block's 16-dot shift register can then load at its fixed slot without waiting on RAM arbitration. It sits between the video block's vram_addr/vram_data pins and the memory arbiter.

Parameters:
ADDR_W, 14, word address width (screen bank bit + 8-bit row + 5-bit column).
TIMEOUT, 15, maximum cycles mem_rd may stay high without mem_ack before the request is abandoned (4-bit counter, range 1..15).

Ports:
clk_sys  in  1  system clock; all state on rising edge.
reset_n  in  1  asynchronous active-low reset.
vram_addr  in  ADDR_W  word address requested by video stage.
vram_data  out  16  word for current vram_addr (registered).
vram_valid  out  1  vram_data corresponds to current vram_addr.
mem_addr  out  ADDR_W  RAM read address; stable while mem_rd=1.
mem_rd  out  1  read request; held high until mem_ack.
mem_ack  in  1  one-cycle pulse; mem_data valid in same cycle.
mem_data  in  16  RAM read data.
miss_cnt  out  16  demand-miss counter (present only with the optional feature).

Behaviour:
- Reset (reset_n=0, async): vram_data=0, vram_valid=0, mem_rd=0, mem_addr=0, both entries invalid, state IDLE, cur_addr=0, force_fetch=1, miss_cnt=0.
- Storage: entry C (tag_c, data_c, val_c) holds the current word. Entry N (tag_n, data_n, val_n) holds the prefetched word. vram_data=data_c. vram_valid=val_c && tag_c==cur_addr.
- cur_addr is registered from vram_addr every cycle. change = (vram_addr != cur_addr) || force_fetch. force_fetch clears when the first demand request is issued.
- On change, hit (val_n && tag_n==vram_addr):
  - Next cycle: C <= N, val_n <= 0.
  - vram_data and vram_valid update 1 cycle after vram_addr changes.
  - A prefetch of vram_addr+1 is queued.
- On change, miss:
  - val_c <= 0. A demand fetch of vram_addr is queued. miss_cnt increments (saturates at 16'hFFFF).
  - A queued prefetch, if any, is discarded.
- Address arithmetic: prefetch address = addr+1 modulo 2^ADDR_W. 14'h3FFF wraps to 14'h0000.
- FSM:
  - IDLE: a pending demand has priority over a pending prefetch. On either, go to REQ.
  - REQ: drive mem_addr and mem_rd=1 for one cycle, then go to WAIT.
  - WAIT: mem_rd stays high and mem_addr stays stable.
    - On mem_ack: mem_rd=0 the same edge. Write mem_data into the target entry (demand→C, prefetch→N) only if its tag still equals the address required now. Otherwise discard. Go to IDLE.
    - After a demand fill, queue a prefetch of addr+1.
- Data timing: a demand fill sets data_c/val_c on the mem_ack edge, so vram_valid rises the cycle after mem_ack.
- Latency: a miss that arrives in IDLE with mem_ack returned k cycles after mem_rd rises gives vram_valid = 1 at change + 2 + k cycles.
- Address change during WAIT: the in-flight request is never aborted. It completes, its result is kept or discarded per the tag check, and the new demand issues from IDLE on the next cycle.
- Timeout: a 4-bit counter runs in WAIT. When it reaches TIMEOUT without mem_ack: mem_rd <= 0, the request is dropped, go to IDLE. A dropped demand is re-queued (still required). A dropped prefetch is not retried. A mem_ack arriving in IDLE is ignored.
- Simultaneous mem_ack and address change in the same cycle: the fill is evaluated against the new address. The change is handled as a hit or miss after the fill is applied.
- vram_data is never 'X'. It holds its previous value while invalid.
- Reset asserted mid-request: mem_rd drops immediately and all state returns to reset values.

Optional Feature:
VRAM_PREFETCH_STATS_EN.
- Defined: miss_cnt port and counter exist as described. The counter clears only on reset.
- Undefined: the miss_cnt port and counter are omitted. Functional behaviour is otherwise identical.

Test Plan:
- Reset, vram_addr=14'h0100, RAM acks 2 cycles after mem_rd -> mem_addr=0100 demand, then prefetch of 0101. vram_valid=1 at cycle 4 after reset release with the RAM word. miss_cnt=1.
- Step vram_addr 0100→0101 after the prefetch completes -> hit. vram_data = RAM[0101] one cycle later. Next mem_addr=0102. miss_cnt unchanged.
- vram_addr=14'h3FFF filled -> prefetch mem_addr=14'h0000. Then switch to 0000 -> hit, no demand issued.
- Jump 0102→2000 while prefetch 0103 is in WAIT -> 0103 completes, then demand 2000 issues the cycle after its mem_ack. vram_valid=0 until the 2000 fill. miss_cnt increments.
- Withhold mem_ack -> mem_rd falls after 15 WAIT cycles. Demand re-issued with the same mem_addr. A late mem_ack while IDLE is ignored.
- reset_n pulsed low while mem_rd=1 -> mem_rd=0, vram_valid=0, vram_data=0 asynchronously. After release, the fetch restarts from the current vram_addr.
